// File: rtl/udp_rx_demux.sv
// rtl/udp_rx_demux.sv - UDP receive parser steering matching payload to per-port channels
//
// Parses Ethernet/IPv4/UDP headers byte by byte, accepts frames addressed to this
// node's MAC (or broadcast) and IPv4 address with a destination port in
// PORT_BASE..PORT_BASE+NUM_PORTS-1, and forwards exactly the UDP payload bytes.
//
// Ports:
//   clk, reset           : single clock, synchronous active-high reset
//   in_data/in_valid     : frame bytes starting at destination MAC byte 0
//   in_sof/in_eof        : first / last byte of frame (qualified by in_valid)
//   payload*             : registered payload stream, one cycle after the input byte
//   payload_chan         : channel index, constant across a payload
//   frames_ok/_dropped   : saturating debug counters
module udp_rx_demux #(
    parameter logic [47:0] FPGA_MAC     = 48'h00_1A_2B_3C_4D_5E,
    parameter logic [31:0] FPGA_IP      = 32'hC0_00_02_92,
    parameter logic [15:0] PORT_BASE    = 16'd5005,
    parameter int          NUM_PORTS    = 4,
    parameter logic        ACCEPT_BCAST = 1'b1,
    localparam int         CW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          in_eof,
    output logic [7:0]    payload,
    output logic          payload_valid,
    output logic          payload_last,
    output logic          payload_abort,
    output logic [CW-1:0] payload_chan,
    output logic [15:0]   frames_ok,
    output logic [15:0]   frames_dropped
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DRAIN} state_t;

    state_t          r_state, w_state_n;
    logic [5:0]      r_idx, w_idx_n;
    logic [15:0]     r_rem, w_rem_n;
    logic [7:0]      r_hold, w_hold_n;
    logic [CW-1:0]   r_chan, w_chan_n;
    logic            r_mac_hit, w_mac_hit_n;
    logic            r_bc_hit, w_bc_hit_n;
    logic [7:0]      r_payload, w_payload_n;
    logic            r_payload_valid, w_payload_valid_n;
    logic            r_payload_last, w_payload_last_n;
    logic            r_payload_abort, w_payload_abort_n;
    logic [CW-1:0]   r_payload_chan, w_payload_chan_n;
    logic [15:0]     r_frames_ok, r_frames_dropped;

    logic            w_parse, w_fail, w_ok_inc;
    logic [1:0]      w_drop_inc;
    logic [7:0]      w_mac_byte, w_ip_byte;
    logic [5:0]      w_pos;
    logic [15:0]     w_field, w_off;
    logic            w_mac_prev, w_bc_prev;
    logic [16:0]     w_ok_sum, w_drop_sum;

    // An in_sof byte is always header byte 0, whatever state we were in.
    assign w_pos      = in_sof ? 6'd0 : r_idx;
    assign w_field    = {r_hold, in_data};
    assign w_off      = w_field - PORT_BASE;
    assign w_mac_prev = in_sof | r_mac_hit;
    assign w_bc_prev  = in_sof | r_bc_hit;
    // Up to two drops can land in one cycle: an abandoned frame plus a new
    // in_sof byte that itself fails or ends the frame.
    assign w_ok_sum   = {1'b0, r_frames_ok} + {16'd0, w_ok_inc};
    assign w_drop_sum = {1'b0, r_frames_dropped} + {15'd0, w_drop_inc};

    always_comb begin
        w_state_n         = r_state;
        w_idx_n           = r_idx;
        w_rem_n           = r_rem;
        w_hold_n          = r_hold;
        w_chan_n          = r_chan;
        w_mac_hit_n       = r_mac_hit;
        w_bc_hit_n        = r_bc_hit;
        w_payload_n       = r_payload;
        w_payload_valid_n = 1'b0;
        w_payload_last_n  = 1'b0;
        w_payload_abort_n = 1'b0;
        w_payload_chan_n  = r_payload_chan;
        w_ok_inc          = 1'b0;
        w_drop_inc        = 2'd0;
        w_parse           = 1'b0;
        w_fail            = 1'b0;

        case (w_pos[2:0])
            3'd0:    w_mac_byte = FPGA_MAC[47:40];
            3'd1:    w_mac_byte = FPGA_MAC[39:32];
            3'd2:    w_mac_byte = FPGA_MAC[31:24];
            3'd3:    w_mac_byte = FPGA_MAC[23:16];
            3'd4:    w_mac_byte = FPGA_MAC[15:8];
            default: w_mac_byte = FPGA_MAC[7:0];
        endcase
        case (w_pos)
            6'd30:   w_ip_byte = FPGA_IP[31:24];
            6'd31:   w_ip_byte = FPGA_IP[23:16];
            6'd32:   w_ip_byte = FPGA_IP[15:8];
            default: w_ip_byte = FPGA_IP[7:0];
        endcase

        if (in_valid) begin
            if (in_sof) begin
                if (r_state == S_PAYLOAD) begin
                    w_payload_abort_n = 1'b1;
                    w_drop_inc        = 2'd1;
                end else if (r_state == S_HDR) begin
                    w_drop_inc = 2'd1;
                end
                w_parse = 1'b1;
            end else begin
                case (r_state)
                    S_HDR: w_parse = 1'b1;
                    S_PAYLOAD: begin
                        w_payload_n       = in_data;
                        w_payload_valid_n = 1'b1;
                        if (r_rem == 16'd1) begin
                            w_payload_last_n = 1'b1;
                            w_ok_inc         = 1'b1;
                            w_state_n        = in_eof ? S_IDLE : S_DRAIN;
                        end else if (in_eof) begin
                            w_payload_abort_n = 1'b1;
                            w_drop_inc        = 2'd1;
                            w_state_n         = S_IDLE;
                        end else begin
                            w_rem_n = r_rem - 16'd1;
                        end
                    end
                    S_DRAIN: if (in_eof) w_state_n = S_IDLE;
                    default: ;
                endcase
            end

            if (w_parse) begin
                w_idx_n   = w_pos + 6'd1;
                w_state_n = S_HDR;
                case (w_pos)
                    6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
                        // Unicast and broadcast are tracked separately so a mix
                        // of the two patterns across bytes is rejected.
                        w_mac_hit_n = w_mac_prev & (in_data == w_mac_byte);
                        w_bc_hit_n  = w_bc_prev & ACCEPT_BCAST & (in_data == 8'hFF);
                        w_fail      = ~(w_mac_hit_n | w_bc_hit_n);
                    end
                    6'd12: w_fail = (in_data != 8'h08);
                    6'd13: w_fail = (in_data != 8'h00);
                    6'd14: w_fail = (in_data != 8'h45);
                    6'd23: w_fail = (in_data != 8'h11);
                    6'd30, 6'd31, 6'd32, 6'd33: w_fail = (in_data != w_ip_byte);
                    6'd36, 6'd38: w_hold_n = in_data;
                    6'd37: begin
                        // 16-bit wrap makes ports below PORT_BASE fail too.
                        w_fail   = (w_off >= 16'(NUM_PORTS));
                        w_chan_n = w_off[CW-1:0];
                    end
                    6'd39: begin
                        w_fail  = (w_field < 16'd8);
                        w_rem_n = w_field - 16'd8;
                    end
                    default: ;
                endcase

                if (w_fail || in_eof) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                    w_state_n  = in_eof ? S_IDLE : S_DRAIN;
                end else if (w_pos == 6'd41) begin
                    if (r_rem == 16'd0) begin
                        w_ok_inc  = 1'b1;
                        w_state_n = S_DRAIN;
                    end else begin
                        w_payload_chan_n = r_chan;
                        w_state_n        = S_PAYLOAD;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_idx            <= 6'd0;
            r_rem            <= 16'd0;
            r_hold           <= 8'd0;
            r_chan           <= '0;
            r_mac_hit        <= 1'b0;
            r_bc_hit         <= 1'b0;
            r_payload        <= 8'd0;
            r_payload_valid  <= 1'b0;
            r_payload_last   <= 1'b0;
            r_payload_abort  <= 1'b0;
            r_payload_chan   <= '0;
            r_frames_ok      <= 16'd0;
            r_frames_dropped <= 16'd0;
        end else begin
            r_state          <= w_state_n;
            r_idx            <= w_idx_n;
            r_rem            <= w_rem_n;
            r_hold           <= w_hold_n;
            r_chan           <= w_chan_n;
            r_mac_hit        <= w_mac_hit_n;
            r_bc_hit         <= w_bc_hit_n;
            r_payload        <= w_payload_n;
            r_payload_valid  <= w_payload_valid_n;
            r_payload_last   <= w_payload_last_n;
            r_payload_abort  <= w_payload_abort_n;
            r_payload_chan   <= w_payload_chan_n;
            r_frames_ok      <= w_ok_sum[16] ? 16'hFFFF : w_ok_sum[15:0];
            r_frames_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign payload        = r_payload;
    assign payload_valid  = r_payload_valid;
    assign payload_last   = r_payload_last;
    assign payload_abort  = r_payload_abort;
    assign payload_chan   = r_payload_chan;
    assign frames_ok      = r_frames_ok;
    assign frames_dropped = r_frames_dropped;

endmodule

// File: tb/tb_udp_rx_demux.sv
// tb/tb_udp_rx_demux.sv - self-checking bench for udp_rx_demux
module tb_udp_rx_demux;

    typedef logic [7:0] bq_t[$];

    localparam logic [47:0] FPGA_MAC  = 48'h00_1A_2B_3C_4D_5E;
    localparam logic [31:0] FPGA_IP   = 32'hC0_00_02_92;
    localparam logic [15:0] PORT_BASE = 16'd5005;
    localparam int          NUM_PORTS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid, in_sof, in_eof;
    logic [7:0]  payload, b_payload;
    logic        payload_valid, payload_last, payload_abort;
    logic        b_payload_valid, b_payload_last, b_payload_abort;
    logic [1:0]  payload_chan, b_payload_chan;
    logic [15:0] frames_ok, frames_dropped, b_frames_ok, b_frames_dropped;

    int errors = 0;
    int checks = 0;
    int e_ok = 0, e_drop = 0, e_ok1 = 0, e_drop1 = 0;

    always #10 clk = ~clk;

    udp_rx_demux dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_eof(in_eof), .payload(payload),
        .payload_valid(payload_valid), .payload_last(payload_last),
        .payload_abort(payload_abort), .payload_chan(payload_chan),
        .frames_ok(frames_ok), .frames_dropped(frames_dropped)
    );

    udp_rx_demux #(.ACCEPT_BCAST(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_eof(in_eof), .payload(b_payload),
        .payload_valid(b_payload_valid), .payload_last(b_payload_last),
        .payload_abort(b_payload_abort), .payload_chan(b_payload_chan),
        .frames_ok(b_frames_ok), .frames_dropped(b_frames_dropped)
    );

    // Payload monitor for the main instance
    bq_t mon_q;
    int  mon_last_cnt, mon_last_pos, mon_abort_cnt, mon_abort_pos, mon_chan, mon_chan_bad;

    always @(negedge clk) begin
        if (payload_valid) begin
            if (mon_q.size() == 0) mon_chan = int'(payload_chan);
            else if (int'(payload_chan) != mon_chan) mon_chan_bad++;
            mon_q.push_back(payload);
        end
        if (payload_last) begin mon_last_cnt++; mon_last_pos = mon_q.size(); end
        if (payload_abort) begin mon_abort_cnt++; mon_abort_pos = mon_q.size(); end
    end

    task automatic mon_clear();
        mon_q.delete();
        mon_last_cnt = 0; mon_last_pos = -1;
        mon_abort_cnt = 0; mon_abort_pos = -1;
        mon_chan = -1; mon_chan_bad = 0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic int q_diff(input bq_t a, input bq_t b);
        int d;
        d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) d++;
        return d;
    endfunction

    function automatic bq_t build(input logic [47:0] mac, input logic [31:0] ip,
                                  input logic [15:0] etype, input logic [7:0] vihl,
                                  input logic [7:0] proto, input logic [15:0] dport,
                                  input logic [15:0] ulen, input bq_t pl);
        bq_t q;
        for (int i = 0; i < 6; i++) q.push_back(8'(mac >> (40 - 8 * i)));
        for (int i = 6; i < 12; i++) q.push_back(8'($urandom));
        q.push_back(etype[15:8]); q.push_back(etype[7:0]);
        q.push_back(vihl);
        for (int i = 15; i < 23; i++) q.push_back(8'($urandom));
        q.push_back(proto);
        for (int i = 24; i < 30; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) q.push_back(8'(ip >> (24 - 8 * i)));
        q.push_back(8'($urandom)); q.push_back(8'($urandom));
        q.push_back(dport[15:8]); q.push_back(dport[7:0]);
        q.push_back(ulen[15:8]); q.push_back(ulen[7:0]);
        q.push_back(8'($urandom)); q.push_back(8'($urandom));
        foreach (pl[i]) q.push_back(pl[i]);
        return q;
    endfunction

    function automatic bq_t add_tail(input bq_t f);
        bq_t q;
        q = f;
        while (q.size() < 60) q.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: what a whole frame (ending with in_eof) must produce
    task automatic model(input bq_t f, input bit bcast, output bq_t pl, output int chan,
                         output bit ok, output bit drop, output bit abort);
        int n;
        bit is_me, is_bc, hdr_ok;
        logic [15:0] dp, ul, off, rem;
        n = f.size();
        pl.delete(); chan = 0; ok = 0; drop = 0; abort = 0;
        if (n <= 42) begin drop = 1; return; end
        is_me = 1; is_bc = bcast;
        for (int i = 0; i < 6; i++) begin
            if (f[i] != 8'(FPGA_MAC >> (40 - 8 * i))) is_me = 0;
            if (f[i] != 8'hFF) is_bc = 0;
        end
        dp  = {f[36], f[37]};
        ul  = {f[38], f[39]};
        off = dp - PORT_BASE;
        hdr_ok = (is_me || is_bc) && f[12] == 8'h08 && f[13] == 8'h00 && f[14] == 8'h45
                 && f[23] == 8'h11 && {f[30], f[31], f[32], f[33]} == FPGA_IP
                 && off < NUM_PORTS && ul >= 16'd8;
        if (!hdr_ok) begin drop = 1; return; end
        chan = int'(off);
        rem  = ul - 16'd8;
        if (rem == 16'd0) begin ok = 1; return; end
        for (int i = 0; i < int'(rem) && 42 + i < n; i++) pl.push_back(f[42 + i]);
        if (n - 42 >= int'(rem)) ok = 1;
        else begin drop = 1; abort = 1; end
    endtask

    task automatic send_frame(input bq_t f, input int gap, input bit do_eof);
        for (int i = 0; i < f.size(); i++) begin
            in_data  = f[i];
            in_valid = 1'b1;
            in_sof   = (i == 0);
            in_eof   = do_eof && (i == f.size() - 1);
            @(posedge clk); #1;
            in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({payload_valid, payload_last, payload_abort} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b expected 000", {payload_valid, payload_last, payload_abort}); end
        checks++; if (payload !== 8'h00 || payload_chan !== 2'd0) begin errors++;
            $display("FAIL reset_data_chan: got %h/%0d expected 00/0", payload, payload_chan); end
        checks++; if (frames_ok !== 16'd0 || frames_dropped !== 16'd0) begin errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", frames_ok, frames_dropped); end
        @(posedge clk); #1;
        reset = 1'b0;
        mon_clear();
    endtask

    task automatic test_valid_frame();
        bq_t pl, f;
        pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE); pl.push_back(8'hEF);
        f = build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5007, 16'd12, pl);
        for (int i = 0; i < 10; i++) f.push_back(8'hA5);
        for (int i = 0; i < 4; i++) f.push_back(8'h5A);
        mon_clear();
        send_frame(f, 3, 1'b1);
        settle();
        e_ok = sat_inc(e_ok); e_ok1 = sat_inc(e_ok1);
        checks++; if (q_diff(mon_q, pl) != 0) begin errors++;
            $display("FAIL valid_payload: got %0d bytes expected 4 (diff %0d)", mon_q.size(), q_diff(mon_q, pl)); end
        checks++; if (mon_chan != 2 || mon_chan_bad != 0) begin errors++;
            $display("FAIL valid_chan: got %0d (unstable %0d) expected 2", mon_chan, mon_chan_bad); end
        checks++; if (mon_last_cnt != 1 || mon_last_pos != 4) begin errors++;
            $display("FAIL valid_last: got cnt %0d pos %0d expected 1 at 4", mon_last_cnt, mon_last_pos); end
        checks++; if (mon_abort_cnt != 0) begin errors++;
            $display("FAIL valid_abort: got %0d expected 0", mon_abort_cnt); end
        checks++; if (frames_ok !== 16'(e_ok) || frames_dropped !== 16'(e_drop)) begin errors++;
            $display("FAIL valid_counters: got %0d/%0d expected %0d/%0d", frames_ok, frames_dropped, e_ok, e_drop); end
    endtask

    task automatic test_header_rejects();
        bq_t pl;
        pl = rand_bytes(4);
        mon_clear();
        send_frame(add_tail(build(FPGA_MAC ^ 48'h1, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5005, 16'd12, pl)), 0, 1'b1);
        send_frame(add_tail(build(FPGA_MAC, FPGA_IP ^ 32'h100, 16'h0800, 8'h45, 8'h11, 16'd5005, 16'd12, pl)), 1, 1'b1);
        send_frame(add_tail(build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5004, 16'd12, pl)), 0, 1'b1);
        send_frame(add_tail(build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5009, 16'd12, pl)), 2, 1'b1);
        settle();
        for (int i = 0; i < 4; i++) begin e_drop = sat_inc(e_drop); e_drop1 = sat_inc(e_drop1); end
        checks++; if (mon_q.size() != 0) begin errors++;
            $display("FAIL reject_payload: got %0d bytes expected 0", mon_q.size()); end
        checks++; if (frames_dropped !== 16'(e_drop) || frames_ok !== 16'(e_ok)) begin errors++;
            $display("FAIL reject_counters: got %0d/%0d expected %0d/%0d", frames_ok, frames_dropped, e_ok, e_drop); end
    endtask

    task automatic test_bcast();
        bq_t pl;
        pl = rand_bytes(3);
        mon_clear();
        send_frame(add_tail(build(48'hFFFF_FFFF_FFFF, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5005, 16'd11, pl)), 1, 1'b1);
        settle();
        e_ok = sat_inc(e_ok); e_drop1 = sat_inc(e_drop1);
        checks++; if (q_diff(mon_q, pl) != 0 || mon_chan != 0) begin errors++;
            $display("FAIL bcast_payload: got %0d bytes chan %0d expected 3 bytes chan 0", mon_q.size(), mon_chan); end
        checks++; if (frames_ok !== 16'(e_ok)) begin errors++;
            $display("FAIL bcast_accept_ok: got %0d expected %0d", frames_ok, e_ok); end
        checks++; if (b_frames_dropped !== 16'(e_drop1) || b_frames_ok !== 16'(e_ok1)) begin errors++;
            $display("FAIL bcast_reject_counters: got %0d/%0d expected %0d/%0d", b_frames_ok, b_frames_dropped, e_ok1, e_drop1); end
    endtask

    task automatic test_udp_len();
        bq_t none;
        mon_clear();
        send_frame(add_tail(build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5006, 16'd8, none)), 0, 1'b1);
        settle();
        e_ok = sat_inc(e_ok); e_ok1 = sat_inc(e_ok1);
        checks++; if (mon_q.size() != 0 || frames_ok !== 16'(e_ok)) begin errors++;
            $display("FAIL len8: got %0d bytes ok %0d expected 0 bytes ok %0d", mon_q.size(), frames_ok, e_ok); end
        send_frame(add_tail(build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5006, 16'd4, none)), 0, 1'b1);
        settle();
        e_drop = sat_inc(e_drop); e_drop1 = sat_inc(e_drop1);
        checks++; if (mon_q.size() != 0 || frames_dropped !== 16'(e_drop)) begin errors++;
            $display("FAIL len4: got %0d bytes dropped %0d expected 0 bytes dropped %0d", mon_q.size(), frames_dropped, e_drop); end
    endtask

    task automatic test_truncation();
        bq_t pl;
        pl = rand_bytes(10);
        mon_clear();
        send_frame(build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5008, 16'd100, pl), 1, 1'b1);
        settle();
        e_drop = sat_inc(e_drop); e_drop1 = sat_inc(e_drop1);
        checks++; if (q_diff(mon_q, pl) != 0 || mon_chan != 3) begin errors++;
            $display("FAIL trunc_payload: got %0d bytes chan %0d expected 10 bytes chan 3", mon_q.size(), mon_chan); end
        checks++; if (mon_abort_cnt != 1 || mon_abort_pos != 10 || mon_last_cnt != 0) begin errors++;
            $display("FAIL trunc_abort: got abort %0d at %0d last %0d expected 1 at 10 last 0", mon_abort_cnt, mon_abort_pos, mon_last_cnt); end
        checks++; if (frames_dropped !== 16'(e_drop) || frames_ok !== 16'(e_ok)) begin errors++;
            $display("FAIL trunc_counters: got %0d/%0d expected %0d/%0d", frames_ok, frames_dropped, e_ok, e_drop); end
    endtask

    task automatic test_sof_mid_payload();
        bq_t pl1, pl2, both;
        pl1 = rand_bytes(5);
        pl2 = rand_bytes(4);
        both = pl1;
        foreach (pl2[i]) both.push_back(pl2[i]);
        mon_clear();
        send_frame(build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5006, 16'd100, pl1), 0, 1'b0);
        send_frame(add_tail(build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5006, 16'd12, pl2)), 1, 1'b1);
        settle();
        e_drop = sat_inc(e_drop); e_drop1 = sat_inc(e_drop1);
        e_ok = sat_inc(e_ok); e_ok1 = sat_inc(e_ok1);
        checks++; if (q_diff(mon_q, both) != 0 || mon_chan != 1 || mon_chan_bad != 0) begin errors++;
            $display("FAIL sofmid_payload: got %0d bytes chan %0d expected 9 bytes chan 1", mon_q.size(), mon_chan); end
        checks++; if (mon_abort_cnt != 1 || mon_abort_pos != 5) begin errors++;
            $display("FAIL sofmid_abort: got %0d at %0d expected 1 at 5", mon_abort_cnt, mon_abort_pos); end
        checks++; if (mon_last_cnt != 1 || mon_last_pos != 9) begin errors++;
            $display("FAIL sofmid_last: got %0d at %0d expected 1 at 9", mon_last_cnt, mon_last_pos); end
        checks++; if (frames_ok !== 16'(e_ok) || frames_dropped !== 16'(e_drop)) begin errors++;
            $display("FAIL sofmid_counters: got %0d/%0d expected %0d/%0d", frames_ok, frames_dropped, e_ok, e_drop); end
    endtask

    task automatic test_random();
        bq_t f, pl, pl1;
        int chan, chan1, r, t;
        bit ok, drop, abort, ok1, drop1, abort1;
        logic [47:0] mac;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            mac = (r < 6) ? FPGA_MAC : (r < 8) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
            f = build(mac,
                      ($urandom_range(0, 9) < 9) ? FPGA_IP : 32'($urandom),
                      ($urandom_range(0, 9) < 9) ? 16'h0800 : 16'h86DD,
                      ($urandom_range(0, 9) < 9) ? 8'h45 : 8'h46,
                      ($urandom_range(0, 9) < 9) ? 8'h11 : 8'h06,
                      16'(32'(PORT_BASE) + $urandom_range(0, 7) - 2),
                      16'($urandom_range(0, 30)),
                      rand_bytes($urandom_range(0, 30)));
            t = $urandom_range(0, 9);
            if (t < 6) f = add_tail(f);
            else if (t >= 8) begin
                r = $urandom_range(1, f.size());
                while (f.size() > r) void'(f.pop_back());
            end
            model(f, 1'b1, pl, chan, ok, drop, abort);
            model(f, 1'b0, pl1, chan1, ok1, drop1, abort1);
            mon_clear();
            send_frame(f, $urandom_range(0, 2), 1'b1);
            settle();
            if (ok) e_ok = sat_inc(e_ok);
            if (drop) e_drop = sat_inc(e_drop);
            if (ok1) e_ok1 = sat_inc(e_ok1);
            if (drop1) e_drop1 = sat_inc(e_drop1);
            checks++; if (q_diff(mon_q, pl) != 0) begin errors++;
                $display("FAIL rand%0d_payload: got %0d bytes expected %0d (diff %0d)", k, mon_q.size(), pl.size(), q_diff(mon_q, pl)); end
            checks++; if (mon_abort_cnt != int'(abort) || mon_last_cnt != int'(ok && pl.size() > 0)) begin errors++;
                $display("FAIL rand%0d_flags: got abort %0d last %0d expected %0d/%0d", k, mon_abort_cnt, mon_last_cnt, abort, ok && pl.size() > 0); end
            if (pl.size() > 0) begin
                checks++; if (mon_chan != chan || mon_chan_bad != 0) begin errors++;
                    $display("FAIL rand%0d_chan: got %0d expected %0d", k, mon_chan, chan); end
            end
            checks++; if (frames_ok !== 16'(e_ok) || frames_dropped !== 16'(e_drop)) begin errors++;
                $display("FAIL rand%0d_counters: got %0d/%0d expected %0d/%0d", k, frames_ok, frames_dropped, e_ok, e_drop); end
            checks++; if (b_frames_ok !== 16'(e_ok1) || b_frames_dropped !== 16'(e_drop1)) begin errors++;
                $display("FAIL rand%0d_nb_counters: got %0d/%0d expected %0d/%0d", k, b_frames_ok, b_frames_dropped, e_ok1, e_drop1); end
        end
    endtask

    task automatic test_saturation();
        bq_t one;
        int n;
        one.push_back(8'h00);
        n = 65534 - e_drop;
        for (int i = 0; i < n; i++) begin
            in_data = 8'($urandom); in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        settle();
        e_drop = 65534;
        e_drop1 = (e_drop1 + n > 65535) ? 65535 : e_drop1 + n;
        checks++; if (frames_dropped !== 16'hFFFE) begin errors++;
            $display("FAIL sat_preload: got %h expected fffe", frames_dropped); end
        send_frame(one, 0, 1'b1);
        settle();
        checks++; if (frames_dropped !== 16'hFFFF) begin errors++;
            $display("FAIL sat_reach: got %h expected ffff", frames_dropped); end
        send_frame(one, 0, 1'b1);
        settle();
        e_drop = 65535; e_drop1 = 65535;
        checks++; if (frames_dropped !== 16'hFFFF || b_frames_dropped !== 16'(e_drop1)) begin errors++;
            $display("FAIL sat_hold: got %h/%h expected ffff/%h", frames_dropped, b_frames_dropped, e_drop1); end
        checks++; if (frames_ok !== 16'(e_ok)) begin errors++;
            $display("FAIL sat_ok_unchanged: got %0d expected %0d", frames_ok, e_ok); end
    endtask

    task automatic test_reset_mid_payload();
        bq_t pl, pl2;
        pl = rand_bytes(3);
        pl2 = rand_bytes(4);
        mon_clear();
        send_frame(build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5008, 16'd100, pl), 0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (mon_q.size() != 3 || mon_chan != 3) begin errors++;
            $display("FAIL rst_pre_payload: got %0d bytes chan %0d expected 3 bytes chan 3", mon_q.size(), mon_chan); end
        checks++; if ({payload_valid, payload_last, payload_abort} !== 3'b000 || payload !== 8'h00 || payload_chan !== 2'd0) begin errors++;
            $display("FAIL rst_outputs: got %b data %h chan %0d expected 000 data 00 chan 0",
                     {payload_valid, payload_last, payload_abort}, payload, payload_chan); end
        checks++; if (frames_ok !== 16'd0 || frames_dropped !== 16'd0) begin errors++;
            $display("FAIL rst_counters: got %0d/%0d expected 0/0", frames_ok, frames_dropped); end
        checks++; if (mon_abort_cnt != 0) begin errors++;
            $display("FAIL rst_no_abort: got %0d expected 0", mon_abort_cnt); end
        @(posedge clk); #1;
        reset = 1'b0;
        e_ok = 0; e_drop = 0; e_ok1 = 0; e_drop1 = 0;
        mon_clear();
        send_frame(add_tail(build(FPGA_MAC, FPGA_IP, 16'h0800, 8'h45, 8'h11, 16'd5005, 16'd12, pl2)), 0, 1'b1);
        settle();
        e_ok = 1; e_ok1 = 1;
        checks++; if (q_diff(mon_q, pl2) != 0 || mon_last_pos != 4 || mon_chan != 0) begin errors++;
            $display("FAIL rst_next_frame: got %0d bytes last at %0d chan %0d expected 4 at 4 chan 0", mon_q.size(), mon_last_pos, mon_chan); end
        checks++; if (frames_ok !== 16'(e_ok) || frames_dropped !== 16'(e_drop)) begin errors++;
            $display("FAIL rst_next_counters: got %0d/%0d expected %0d/%0d", frames_ok, frames_dropped, e_ok, e_drop); end
    endtask

    initial begin
        mon_clear();
        test_reset();
        test_valid_frame();
        test_header_rejects();
        test_bcast();
        test_udp_len();
        test_truncation();
        test_sof_mid_payload();
        test_random();
        test_saturation();
        test_reset_mid_payload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
